combine_user_scheduler: RTL and testbench
=========================================

# combine_user_scheduler

Parametrised round-robin scheduler for the combine stage. It watches per-user ping-pong buffer indicators and counts the ready codeblock buffers per user. It grants the combine engine to one user at a time, picking the next eligible user in a single cycle instead of rotating one position per cycle. It sits between the input-buffer ping-pong writers and the combine datapath, and adds per-user enable masking, queued readiness, an overflow flag and a completion watchdog.

## Interface
- NUM_USERS, 8, number of users/channels (2..32)
- IDX_W, $clog2(NUM_USERS), width of user index
- PEND_W, 2, per-user pending-buffer counter width (saturating)
- TIMEOUT_CYCLES, 65535, max cycles in PROGRESS before abort; 0 disables the watchdog

- i_core_clk  in  1  core clock, all logic rising-edge
- i_rx_rst  in  1  synchronous, active-high reset
- i_slot_start  in  1  single-cycle pulse; starts scheduling from IDLE
- i_slot_stop  in  1  single-cycle pulse; returns to IDLE after the current grant completes
- i_user_enable  in  NUM_USERS  per-user arbitration mask; a disabled user keeps counting but is never granted
- i_pingpong_ind  in  NUM_USERS  per-user ping-pong indicator; each toggle means one buffer is ready
- i_cb_combine_comp  in  1  completion pulse from the combine engine for the granted user
- o_combine_req  out  1  high throughout PROGRESS
- o_combine_user_idx  out  IDX_W  granted user; valid while o_combine_req is high; holds the last grant otherwise
- o_timeout  out  1  one-cycle pulse when the watchdog aborts a grant
- o_pend_overflow  out  NUM_USERS  sticky per-user flag: a toggle arrived while that user's counter was saturated
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, ARB, PROGRESS, COMP (one-hot). Reset state is IDLE.
- Toggle detect:
  - ind_d holds i_pingpong_ind from the previous cycle; ind_d resets to 0.
  - toggle[i] = i_pingpong_ind[i] ^ ind_d[i].
- Pending counter pend[i]:
  - A toggle increments it.
  - An accepted completion (or timeout abort) for user i decrements it.
  - Both in the same cycle: the counter is unchanged.
  - At 2^PEND_W-1, a further toggle leaves it saturated and sets o_pend_overflow[i]. The flag clears only on reset.
- Eligible: elig[i] = (pend[i] != 0) & i_user_enable[i].
- Arbitration pointer:
  - ptr resets to NUM_USERS-1.
  - In ARB, the grant goes to the first eligible index scanning ptr+1, ptr+2, … modulo NUM_USERS.
- Transitions:
  - IDLE→ARB on i_slot_start.
  - ARB→PROGRESS when any elig. The chosen index is registered into o_combine_user_idx on the same edge.
  - ARB→IDLE when stop_pending is set.
  - ARB stays in ARB otherwise.
  - PROGRESS→COMP on i_cb_combine_comp or watchdog expiry. On that edge, pend[idx] decrements and ptr ← idx.
  - COMP→ARB, or COMP→IDLE if stop_pending.
- stop_pending:
  - Set by i_slot_stop in any non-IDLE state.
  - Cleared on entry to IDLE.
  - i_slot_stop in IDLE is ignored, and so is i_slot_start outside IDLE.
- Watchdog:
  - The counter clears on PROGRESS entry and counts each PROGRESS cycle.
  - When it reaches TIMEOUT_CYCLES without completion: abort, o_timeout=1 for one cycle (the COMP cycle), and the pending buffer is dropped (decremented).
  - Completion and expiry in the same cycle count as completion; no o_timeout.
- Changing i_user_enable during PROGRESS does not abort the current grant.

## Timing
- Reset values:
  - Outputs: o_combine_req=0, o_combine_user_idx=0, o_timeout=0, o_pend_overflow=0, o_busy=0.
  - Internal: pend=0, ptr=NUM_USERS-1.
- Toggle at cycle t → pend visible at t+1 → earliest grant edge at end of t+1 (if in ARB) → o_combine_req high at t+2.
- Completion sampled at cycle c → COMP at c+1 → ARB at c+2 → next o_combine_req at c+3 at the earliest. Minimum req-low gap between grants is 2 cycles.
- i_cb_combine_comp outside PROGRESS is ignored.
- Reset is synchronous and wins over every other event in the same cycle, including mid-grant: the next cycle is IDLE with all counters cleared.

## Structure
- Shared package: state encoding constants (IDLE/ARB/PROGRESS/COMP) and a function for the index width.
- One sub-module: combine_rr_arbiter, which is combinational. Inputs are elig[NUM_USERS] and ptr. Outputs are gnt_valid and gnt_idx.
  - Implemented with a double-width masked priority encoder.
  - Verified standalone against a reference model.

## Test plan
- Reset, i_slot_start, toggle users 2 and 5 in the same cycle → grants idx 2 then 5 (ptr starts at 7). o_combine_req rises 2 cycles after the toggle.
- NUM_USERS=8, ptr=6, users 1 and 7 pending → grant 7, then 1 (wrap-around).
- Four toggles on user 3 with PEND_W=2 → pend saturates at 3, o_pend_overflow[3]=1. Three grants of user 3 follow, then the scheduler idles in ARB.
- User 4 pending with i_user_enable[4]=0 → no grant. Enable asserted → grant to 4 on the next ARB edge.
- TIMEOUT_CYCLES=10, grant with no completion → o_timeout pulses after 10 PROGRESS cycles and pend decrements. Completion and expiry in the same cycle → no pulse.
- i_slot_stop during PROGRESS → grant finishes, then COMP→IDLE and o_busy=0. i_rx_rst mid-PROGRESS → next cycle IDLE with all outputs at reset values.

Source files
------------

// File: rtl/combine_user_scheduler_pkg.sv
// combine_user_scheduler_pkg: shared state encoding and index-width helper for the combine scheduler
package combine_user_scheduler_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    ARB      = 4'b0010,
    PROGRESS = 4'b0100,
    COMP     = 4'b1000
  } state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/combine_rr_arbiter.sv
// combine_rr_arbiter: single-cycle round-robin pick of the first eligible user after ptr
module combine_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  always_comb begin
    dbl = {elig, elig};
    masked = '0;
    gnt_idx = '0;
    for (int j = 0; j < 2 * N; j++)
      masked[j] = dbl[j] && (j > int'(ptr)) && (j <= int'(ptr) + N);
    for (int j = 2 * N - 1; j >= 0; j--)
      if (masked[j]) gnt_idx = W'((j >= N) ? j - N : j);
    gnt_valid = |masked;
  end
endmodule

// File: rtl/combine_user_scheduler.sv
// combine_user_scheduler: round-robin grant of the combine engine to users with ready ping-pong buffers
module combine_user_scheduler
  import combine_user_scheduler_pkg::*;
#(
  parameter int NUM_USERS      = 8,
  parameter int IDX_W          = idx_width(NUM_USERS),
  parameter int PEND_W         = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rst,
  input  logic                 i_slot_start,
  input  logic                 i_slot_stop,
  input  logic [NUM_USERS-1:0] i_user_enable,
  input  logic [NUM_USERS-1:0] i_pingpong_ind,
  input  logic                 i_cb_combine_comp,
  output logic                 o_combine_req,
  output logic [IDX_W-1:0]     o_combine_user_idx,
  output logic                 o_timeout,
  output logic [NUM_USERS-1:0] o_pend_overflow,
  output logic                 o_busy
);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, nxt;
  logic [NUM_USERS-1:0] ind_d, toggle, elig, dec;
  logic [PEND_W-1:0] pend [NUM_USERS];
  logic [IDX_W-1:0] ptr, gnt_idx;
  logic [WD_W-1:0] wd;
  logic gnt_valid, stop_pending, expire, done;
  assign toggle = i_pingpong_ind ^ ind_d;
  assign expire = (TIMEOUT_CYCLES != 0) && (state == PROGRESS) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign done = (state == PROGRESS) && (i_cb_combine_comp || expire);
  assign o_combine_req = (state == PROGRESS);
  assign o_busy = (state != IDLE);
  combine_rr_arbiter #(.N(NUM_USERS), .W(IDX_W)) u_arb (
    .elig     (elig),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );
  always_comb begin
    elig = '0;
    dec = '0;
    for (int i = 0; i < NUM_USERS; i++) begin
      elig[i] = (pend[i] != '0) && i_user_enable[i];
      dec[i] = done && (o_combine_user_idx == IDX_W'(i));
    end
  end
  always_comb begin
    nxt = state;
    nxt = (state == IDLE)     ? (i_slot_start ? ARB : IDLE) :
          (state == ARB)      ? (stop_pending ? IDLE : gnt_valid ? PROGRESS : ARB) :
          (state == PROGRESS) ? (done ? COMP : PROGRESS) :
                                (stop_pending ? IDLE : ARB);
  end
  always_ff @(posedge i_core_clk) state <= i_rx_rst ? IDLE : nxt;
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      ind_d <= '0;
      o_pend_overflow <= '0;
      ptr <= IDX_W'(NUM_USERS - 1);
      o_combine_user_idx <= '0;
      wd <= '0;
      o_timeout <= 1'b0;
      stop_pending <= 1'b0;
      for (int i = 0; i < NUM_USERS; i++) pend[i] <= '0;
    end else begin
      ind_d <= i_pingpong_ind;
      o_timeout <= expire && !i_cb_combine_comp;
      stop_pending <= (nxt == IDLE) ? 1'b0 : stop_pending | (i_slot_stop && state != IDLE);
      if (state == ARB && nxt == PROGRESS) begin
        o_combine_user_idx <= gnt_idx;
        wd <= '0;
      end else if (state == PROGRESS) begin
        wd <= wd + 1'b1;
      end
      if (done) ptr <= o_combine_user_idx;
      for (int i = 0; i < NUM_USERS; i++) begin
        if (toggle[i] && !dec[i]) begin
          if (pend[i] == '1) o_pend_overflow[i] <= 1'b1;
          else pend[i] <= pend[i] + 1'b1;
        end else if (dec[i] && !toggle[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_combine_user_scheduler.sv
// tb_combine_user_scheduler: directed table, corner sequences and random run against a reference model
module tb_combine_user_scheduler;
  localparam int N = 8;
  localparam int PMAX = 3;
  localparam int TO = 10;
  logic clk = 1'b0;
  logic rst, start, stop, comp;
  logic [N-1:0] en, ind;
  logic req, tmo, busy;
  logic [2:0] idx;
  logic [N-1:0] ovf;
  int checks = 0;
  int errors = 0;
  int m_ph, m_ptr, m_idx, m_wd;
  int m_pend [N];
  bit [N-1:0] m_ovf, m_prev;
  bit m_to, m_stop;
  typedef struct {
    logic start;
    logic [7:0] tog;
    logic comp;
    logic req;
    int idx;
    logic busy;
  } vec_t;
  vec_t tbl [10];
  always #5 clk = ~clk;
  combine_user_scheduler #(.NUM_USERS(N), .PEND_W(2), .TIMEOUT_CYCLES(TO)) dut (
    .i_core_clk        (clk),
    .i_rx_rst          (rst),
    .i_slot_start      (start),
    .i_slot_stop       (stop),
    .i_user_enable     (en),
    .i_pingpong_ind    (ind),
    .i_cb_combine_comp (comp),
    .o_combine_req     (req),
    .o_combine_user_idx(idx),
    .o_timeout         (tmo),
    .o_pend_overflow   (ovf),
    .o_busy            (busy)
  );
  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask
  function automatic void model_step();
    int g, nph, u;
    bit expire, done, tg, dc;
    if (rst) begin
      m_ph = 0; m_ptr = N - 1; m_idx = 0; m_wd = 0;
      m_ovf = '0; m_prev = '0; m_to = 0; m_stop = 0;
      for (int k = 0; k < N; k++) m_pend[k] = 0;
      return;
    end
    g = -1;
    nph = m_ph;
    expire = (m_ph == 2) && (TO != 0) && (m_wd + 1 == TO);
    done = (m_ph == 2) && (comp || expire);
    if (m_ph == 0 && start) nph = 1;
    else if (m_ph == 1) begin
      if (m_stop) nph = 0;
      else begin
        for (int k = 1; k <= N; k++) begin
          u = (m_ptr + k) % N;
          if (g < 0 && m_pend[u] > 0 && en[u]) g = u;
        end
        if (g >= 0) nph = 2;
      end
    end else if (m_ph == 2 && done) nph = 3;
    else if (m_ph == 3) nph = m_stop ? 0 : 1;
    for (int k = 0; k < N; k++) begin
      tg = ind[k] ^ m_prev[k];
      dc = done && (m_idx == k);
      if (tg && !dc) begin
        if (m_pend[k] == PMAX) m_ovf[k] = 1;
        else m_pend[k]++;
      end else if (dc && !tg) m_pend[k]--;
    end
    m_to = expire && !comp;
    if (done) m_ptr = m_idx;
    if (g >= 0) begin
      m_idx = g;
      m_wd = 0;
    end else if (m_ph == 2) m_wd++;
    m_stop = (nph == 0) ? 0 : (m_stop || (m_ph != 0 && stop));
    m_prev = ind;
    m_ph = nph;
  endfunction
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_req", req, m_ph == 2);
    chk("model_idx", idx, m_idx);
    chk("model_busy", busy, m_ph != 0);
    chk("model_timeout", tmo, m_to);
    chk("model_ovf", ovf, m_ovf);
  endtask
  task automatic pulse_tog(input logic [N-1:0] m);
    ind ^= m;
    tick();
  endtask
  task automatic wait_req(input int budget);
    int k = 0;
    while (!req && k < budget) begin
      tick();
      k++;
    end
    chk("req_wait", req, 1);
  endtask
  task automatic complete();
    comp = 1;
    tick();
    comp = 0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b1};
    tbl[1] = '{1'b0, 8'h24, 1'b0, 1'b0, 0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 5, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 5, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 5, 1'b1};
    rst = 1; start = 0; stop = 0; comp = 0; en = '1; ind = '0;
    tick();
    tick();
    chk("rst_req", req, 0);
    chk("rst_idx", idx, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    for (int r = 0; r < 10; r++) begin
      start = tbl[r].start;
      ind ^= tbl[r].tog;
      comp = tbl[r].comp;
      tick();
      start = 0;
      comp = 0;
      chk($sformatf("tbl%0d_req", r), req, tbl[r].req);
      chk($sformatf("tbl%0d_idx", r), idx, tbl[r].idx);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
    end
    pulse_tog(8'h40);
    wait_req(5);
    chk("grant6", idx, 6);
    pulse_tog(8'h82);
    complete();
    wait_req(5);
    chk("wrap7", idx, 7);
    complete();
    wait_req(5);
    chk("wrap1", idx, 1);
    complete();
    en = 8'hF7;
    repeat (4) pulse_tog(8'h08);
    chk("ovf3", ovf[3], 1);
    chk("ovf_masked_req", req, 0);
    en = '1;
    for (int g = 0; g < 3; g++) begin
      wait_req(5);
      chk("sat_grant3", idx, 3);
      complete();
    end
    repeat (6) tick();
    chk("sat_drain_req", req, 0);
    chk("sat_drain_busy", busy, 1);
    en = 8'hEF;
    pulse_tog(8'h10);
    repeat (4) tick();
    chk("masked4_req", req, 0);
    en = '1;
    tick();
    chk("enable4_req", req, 1);
    chk("enable4_idx", idx, 4);
    complete();
    pulse_tog(8'h01);
    wait_req(5);
    repeat (9) begin
      tick();
      chk("wd_hold", req, 1);
    end
    tick();
    chk("tmo_pulse", tmo, 1);
    chk("tmo_req", req, 0);
    tick();
    chk("tmo_clear", tmo, 0);
    repeat (4) tick();
    chk("tmo_dropped", req, 0);
    pulse_tog(8'h01);
    wait_req(5);
    repeat (9) tick();
    complete();
    chk("both_no_tmo", tmo, 0);
    chk("both_req", req, 0);
    repeat (4) tick();
    chk("both_dropped", req, 0);
    pulse_tog(8'h02);
    wait_req(5);
    stop = 1;
    tick();
    stop = 0;
    chk("stop_hold_req", req, 1);
    complete();
    chk("stop_comp_busy", busy, 1);
    tick();
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_req", req, 0);
    start = 1;
    tick();
    start = 0;
    pulse_tog(8'h04);
    wait_req(5);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_tmo", tmo, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_busy", busy, 0);
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 59) == 0);
      comp = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      ind ^= N'($urandom) & N'($urandom) & N'($urandom);
      en = ~(N'($urandom) & N'($urandom) & N'($urandom));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
